// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter
// Round-robin two-port arbiter and one-access sequencer for the data memory.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [2:0]  a_width,
    input  logic        a_we,
    output logic        a_resp_valid,
    output logic [31:0] a_rdata,
    output logic        a_err,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [2:0]  b_width,
    input  logic        b_we,
    output logic        b_resp_valid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_width,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;        // 1: port B wins a tie
    logic        owner_q, owner_d;  // 1: port B owns the transfer
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  width_q, width_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant_a;
    logic        grant_b;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_width;
    logic        sel_we;
    logic        in_access;

    function automatic logic access_error(input logic [31:0] addr,
                                          input logic [2:0]  width,
                                          input logic        we);
        logic [32:0] size;
        logic [32:0] last;
        logic        illegal;
        logic        misaligned;
        case (width)
            3'b000, 3'b100: size = 33'd1;
            3'b001, 3'b101: size = 33'd2;
            default:        size = 33'd4;
        endcase
        illegal = (width == 3'b011) || (width == 3'b110) || (width == 3'b111) ||
                  (we && width[2]);
        misaligned = ((width[1:0] == 2'b01) && addr[0]) ||
                     ((width[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        last = {1'b0, addr} + size;
        return illegal || misaligned || (last > 33'(MEM_BYTES));
    endfunction

    // Ready is held low while reset is asserted so nothing looks accepted
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if ((state_q == S_IDLE) && !reset) begin
            if (a_req_valid && (!b_req_valid || !rr_q)) begin
                grant_a = 1'b1;
            end else if (b_req_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    assign sel_width = grant_b ? b_width : a_width;
    assign sel_we    = grant_b ? b_we    : a_we;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        width_d = width_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = S_ACCESS;
                    rr_d    = grant_a;
                    owner_d = grant_b;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    width_d = sel_width;
                    we_d    = sel_we;
                    err_d   = access_error(sel_addr, sel_width, sel_we);
                end
            end
            S_ACCESS: begin
                rdata_d = (!err_q && !we_q) ? mem_read_data : 32'd0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            width_q <= 3'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_access        = (state_q == S_ACCESS);
    assign mem_address      = in_access ? addr_q  : 32'd0;
    assign mem_write_data   = in_access ? wdata_q : 32'd0;
    assign mem_width        = in_access ? width_q : 3'd0;
    assign mem_read_enable  = in_access && !err_q && !we_q;
    assign mem_write_enable = in_access && !err_q &&  we_q;

    assign a_resp_valid = (state_q == S_RESP) && !owner_q;
    assign b_resp_valid = (state_q == S_RESP) &&  owner_q;
    assign a_rdata      = a_resp_valid ? rdata_q : 32'd0;
    assign b_rdata      = b_resp_valid ? rdata_q : 32'd0;
    assign a_err        = a_resp_valid && err_q;
    assign b_err        = b_resp_valid && err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter
// Self-checking bench: vector table, corner sequences, random vs reference.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int MEM = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_ready, a_we, a_resp_valid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_width;
    logic        b_req_valid, b_req_ready, b_we, b_resp_valid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_width;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [2:0]  mem_width;
    logic        mem_read_enable, mem_write_enable;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.MEM_BYTES(MEM)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_width(a_width), .a_we(a_we),
        .a_resp_valid(a_resp_valid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_width(b_width), .b_we(b_we),
        .b_resp_valid(b_resp_valid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_width(mem_width), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory instance model: combinational extended read, write on edge
    logic [7:0] mem [MEM];
    logic       clear_mem;
    logic [7:0] m0, m1, m2, m3;

    always_comb begin
        m0 = mem[7'(mem_address)];
        m1 = mem[7'(mem_address + 32'd1)];
        m2 = mem[7'(mem_address + 32'd2)];
        m3 = mem[7'(mem_address + 32'd3)];
        mem_read_data = 32'd0;
        if (mem_read_enable) begin
            case (mem_width)
                3'b000:  mem_read_data = {{24{m0[7]}}, m0};
                3'b001:  mem_read_data = {{16{m1[7]}}, m1, m0};
                3'b010:  mem_read_data = {m3, m2, m1, m0};
                3'b100:  mem_read_data = {24'd0, m0};
                3'b101:  mem_read_data = {16'd0, m1, m0};
                default: mem_read_data = 32'd0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < MEM; i++) mem[i] <= 8'h00;
        end else if (mem_write_enable) begin
            mem[7'(mem_address)] <= mem_write_data[7:0];
            if (mem_width[1:0] != 2'b00) mem[7'(mem_address + 32'd1)] <= mem_write_data[15:8];
            if (mem_width[1:0] == 2'b10) begin
                mem[7'(mem_address + 32'd2)] <= mem_write_data[23:16];
                mem[7'(mem_address + 32'd3)] <= mem_write_data[31:24];
            end
        end
    end

    // Reference model: byte array plus rule-based error and load functions
    logic [7:0] ref_mem [MEM];

    function automatic int size_of(input logic [2:0] w);
        if (w == 3'b000 || w == 3'b100) return 1;
        if (w == 3'b001 || w == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] w, input logic [31:0] a);
        bit     legal;
        longint end_a;
        legal = (w == 3'b000 || w == 3'b001 || w == 3'b010) ||
                (!we && (w == 3'b100 || w == 3'b101));
        if (!legal) return 1'b1;
        if ((a % size_of(w)) != 0) return 1'b1;
        end_a = longint'(a) + longint'(size_of(w));
        return end_a > MEM;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] w);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < size_of(w); k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (w == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (w == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        for (int k = 0; k < size_of(w); k++) ref_mem[int'(a) + k] = d[8*k +: 8];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit p, input logic v, input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        if (!p) begin
            a_req_valid = v; a_we = we; a_width = w; a_addr = a; a_wdata = d;
        end else begin
            b_req_valid = v; b_we = we; b_width = w; b_addr = a; b_wdata = d;
        end
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise
    task automatic do_req(input bit p, input logic we, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output logic re_seen, output logic we_seen);
        logic got;
        got = 1'b0; rd = 32'd0; er = 1'b0; re_seen = 1'b0; we_seen = 1'b0;
        drive(p, 1'b1, we, w, a, d);
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (p ? b_req_ready : a_req_ready) got = 1'b1;
            else @(posedge clk);
        end
        chk("grant", 32'(got), 32'd1);
        if (!got) begin
            drive(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        chk("other_ready_low", 32'(p ? a_req_ready : b_req_ready), 32'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        re_seen = mem_read_enable;
        we_seen = mem_write_enable;
        chk("no_early_resp", 32'(a_resp_valid | b_resp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_valid", 32'(p ? b_resp_valid : a_resp_valid), 32'd1);
        chk("other_resp_low", 32'(p ? a_resp_valid : b_resp_valid), 32'd0);
        rd = p ? b_rdata : a_rdata;
        er = p ? b_err : a_err;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          p;
        logic        we;
        logic [2:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [31:0] rd;
        logic        er, re_s, we_s;
        int          grants [$];
        int          na, nb, diffs;
        logic [2:0]  wsel [8];

        vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b1, 3'b000, 32'h20, 32'h00000080, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 3'b000, 32'h20, 32'h0,        1'b0, 32'hFFFFFF80};
        vt[4]  = '{1'b1, 1'b0, 3'b100, 32'h20, 32'h0,        1'b0, 32'h00000080};
        vt[5]  = '{1'b1, 1'b0, 3'b101, 32'h20, 32'h0,        1'b0, 32'h00000080};
        vt[6]  = '{1'b0, 1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD};
        vt[7]  = '{1'b0, 1'b0, 3'b010, 32'h02, 32'h0,        1'b1, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 3'b001, 32'h03, 32'h0,        1'b1, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h7E, 32'hCAFEF00D, 1'b1, 32'h0};
        vt[10] = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0};
        vt[11] = '{1'b0, 1'b1, 3'b100, 32'h30, 32'h55555555, 1'b1, 32'h0};
        vt[12] = '{1'b1, 1'b1, 3'b001, 32'h7E, 32'h0000BEEF, 1'b0, 32'h0};
        vt[13] = '{1'b0, 1'b0, 3'b101, 32'h7E, 32'h0,        1'b0, 32'h0000BEEF};
        vt[14] = '{1'b0, 1'b0, 3'b010, 32'h7C, 32'h0,        1'b0, 32'hBEEF0000};
        vt[15] = '{1'b1, 1'b0, 3'b010, 32'h80, 32'h0,        1'b1, 32'h0};
        vt[16] = '{1'b0, 1'b0, 3'b100, 32'h7F, 32'h0,        1'b0, 32'h000000BE};
        vt[17] = '{1'b1, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h1,  1'b1, 32'h0};

        wsel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;

        // Reset with a pending request: nothing may be accepted
        reset = 1'b1; clear_mem = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_req_ready), 32'd0);
        chk("rst_resp", 32'({a_resp_valid, b_resp_valid, a_err, b_err}), 32'd0);
        chk("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; clear_mem = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_req(vt[i].p, vt[i].we, vt[i].w, vt[i].a, vt[i].d, rd, er, re_s, we_s);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_re", i), 32'(re_s), 32'(!vt[i].exp_err && !vt[i].we));
            chk($sformatf("vec%0d_we", i), 32'(we_s), 32'(!vt[i].exp_err && vt[i].we));
            if (!vt[i].exp_err && vt[i].we) ref_store(vt[i].a, vt[i].w, vt[i].d);
        end

        // Both ports valid from reset: strict A,B alternation, 3-cycle cadence
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h20, 32'd0);
        na = 0; nb = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("alt_one_ready", 32'(a_req_ready & b_req_ready), 32'd0);
            chk("alt_one_resp", 32'(a_resp_valid & b_resp_valid), 32'd0);
            if (a_req_ready) grants.push_back(0);
            if (b_req_ready) grants.push_back(1);
            if (a_resp_valid) begin
                na++;
                chk("alt_a_rdata", a_rdata, ref_load(32'h10, 3'b010));
            end
            if (b_resp_valid) begin
                nb++;
                chk("alt_b_rdata", b_rdata, ref_load(32'h20, 3'b100));
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("alt_grant_count", 32'(grants.size()), 32'd6);
        for (int g = 0; g < grants.size(); g++)
            chk($sformatf("alt_grant%0d", g), 32'(grants[g]), 32'(g % 2));
        chk("alt_a_resps", 32'(na), 32'd3);
        chk("alt_b_resps", 32'(nb), 32'd3);

        // Reset during the ACCESS cycle of a store
        drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
        begin : wait_grant
            logic got;
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                if (a_req_ready) got = 1'b1;
                else @(posedge clk);
            end
            chk("rst_store_grant", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("rst_store_we_before", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_store_we_after", 32'(mem_write_enable), 32'd0);
        chk("rst_store_addr_after", mem_address, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(a_resp_valid | b_resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        @(negedge clk);
        chk("rst_rr_a_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rr_b_ready", 32'(b_req_ready), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_reload_valid", 32'(a_resp_valid), 32'd1);
        chk("rst_reload_rdata", a_rdata, ref_load(32'h40, 3'b010));
        chk("rst_reload_err", 32'(a_err), 32'd0);
        @(posedge clk); #1;

        // Random single-port traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            bit          p;
            logic        we, e_err;
            logic [2:0]  w;
            logic [31:0] a, d, e_rd;
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            w  = wsel[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) a = $urandom;
            else a = 32'($urandom_range(0, MEM + 3));
            if ($urandom_range(0, 1) == 1) a = a & ~32'(size_of(w) - 1);
            d = $urandom;
            e_err = ref_err(we, w, a);
            e_rd  = (e_err || we) ? 32'd0 : ref_load(a, w);
            do_req(p, we, w, a, d, rd, er, re_s, we_s);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(e_err));
            chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            chk($sformatf("rnd%0d_en", i), 32'({re_s, we_s}), 32'({!e_err && !we, !e_err && we}));
            if (!e_err && we) ref_store(a, w, d);
        end

        diffs = 0;
        for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed data memory. Shares the single data memory port between the CPU load/store unit (port A) and a DMA/debug loader (port B) with round-robin fairness. Checks alignment, range and width encoding, drives exactly one memory access per granted request, and returns a registered response to the owning requester. Sits between the pipeline's memory stage / loader and the data memory instance.

## Interface
- MEM_BYTES, 128, memory size in bytes; accesses ending beyond it are errors
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- a_req_valid  in  1  port A request present
- a_req_ready  out  1  port A request accepted this cycle
- a_addr  in  32  port A byte address
- a_wdata  in  32  port A store data, right-aligned
- a_width  in  3  port A funct3 width code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- a_we  in  1  port A 1 = store, 0 = load
- a_resp_valid  out  1  port A response pulse
- a_rdata  out  32  port A load data (extended per width code)
- a_err  out  1  port A error flag, valid with a_resp_valid
- b_req_valid, b_req_ready, b_addr, b_wdata, b_width, b_we, b_resp_valid, b_rdata, b_err  as port A, for port B
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write data
- mem_width  out  3  to memory width code
- mem_read_enable  out  1  to memory read enable
- mem_write_enable  out  1  to memory write enable
- mem_read_data  in  32  from memory; combinational read, valid while read enable high

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req_valid, grant one; x_req_ready asserted combinationally for the granted port only, same cycle; latch addr/wdata/width/we/owner and error check result; -> ACCESS. No valid -> stay IDLE.
- Grant: only one valid -> that port. Both valid -> port favoured by rr pointer. Pointer resets to favour A; on every grant it flips to favour the non-granted port.
- Error check (latched at grant): misaligned (h with addr[0]=1; w with addr[1:0]!=0); out of range (addr + size > MEM_BYTES, size 1/2/4, computed 33-bit, no wrap); illegal width (011, 110, 111; for stores also 100, 101).
- ACCESS: drive mem_address/mem_width/mem_write_data from latch. No error: mem_read_enable=1 for load or mem_write_enable=1 for store, for exactly this one cycle. Error: both enables 0. Capture mem_read_data into response register at end of cycle for loads; stores capture 0. -> RESP.
- RESP: owner's resp_valid=1, rdata = response register, err = latched error; error or store -> rdata 0. -> IDLE.
- Outside ACCESS: mem enables 0, mem_address/mem_write_data/mem_width 0.
- Responses are single-cycle pulses; requesters cannot back-pressure.
- Requests may change or drop while not ready; nothing is latched until ready.

## Timing
- Reset values: all ready/resp_valid/err/enable outputs 0; rdata and mem buses 0; rr favours A.
- Grant at edge N (ready high cycle N-1->N), memory access cycle N, response cycle N+1; next grant earliest cycle N+2 (IDLE). Throughput 1 request / 3 cycles.
- Store commits to memory on the edge ending ACCESS.
- Reset asserted in any state: immediate return to IDLE, outputs to reset values asynchronously; in-flight request dropped with no response; a store in ACCESS is suppressed if reset rises before the closing edge.
- At most one of a_resp_valid/b_resp_valid and at most one of a_req_ready/b_req_ready high in any cycle.

## Test plan
- Port A sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> grants in IDLE, mem_write_enable one cycle, response 2 cycles after grant; load returns 0xDEADBEEF, err 0.
- Port B sb 0x20 data 0x80, then lb and lbu 0x20 -> 0xFFFFFF80 and 0x00000080; lhu 0x20 with 0x21 = 0 -> 0x00000080.
- Both ports valid continuously from reset -> grants alternate A,B,A,B; each port gets a response for every grant, never both in one cycle.
- Errors: lw 0x02, lh 0x03, sw 0x7E (MEM_BYTES 128), load width 011, store width 100 -> err 1, rdata 0, memory enables never asserted, memory contents unchanged.
- Reset during ACCESS of sw 0x40 data 0x12345678 -> no response, enables drop immediately, later lw 0x40 returns prior value 0x00000000; rr favours A after reset.
